// File: rtl/dll_discriminator_pkg.sv
// Shared constants and types for the code-loop discriminator.
// Widths here track the correlator channel's I2Q2 output.
package dll_discriminator_pkg;

  localparam int DISC_IN_WIDTH  = 38;
  localparam int DISC_FRAC_BITS = 12;
  localparam int DISC_WIDTH     = DISC_FRAC_BITS + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_DIV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/dll_discriminator_serial_divider.sv
// Serial restoring divider, one quotient bit per cycle, MSB first.
// Quotient = floor(numer * 2^(QW-1) / denom), assuming numer <= denom.
module serial_divider #(
  parameter int DW = 39,
  parameter int QW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          abort,
  input  logic          start,
  input  logic [DW-1:0] numer,
  input  logic [DW-1:0] denom,
  output logic          done,
  output logic [QW-1:0] quot
);

  localparam int CW = $clog2(QW + 1);

  logic [DW:0]   rem_q;
  logic [DW:0]   diff;
  logic [CW-1:0] cnt_q;
  logic          run_q;
  logic          ge;

  assign ge   = rem_q >= {1'b0, denom};
  assign diff = rem_q - {1'b0, denom};

  // Shift after the compare so the first step tests numer against denom.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done  <= 1'b0;
      quot  <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        run_q <= 1'b0;
      end else if (start) begin
        rem_q <= {1'b0, numer};
        quot  <= '0;
        cnt_q <= CW'(QW);
        run_q <= 1'b1;
      end else if (run_q) begin
        rem_q <= (ge ? diff : rem_q) << 1;
        quot  <= {quot[QW-2:0], ge};
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dll_discriminator.sv
// Code-loop discriminator: normalised (E-L)/(E+L) in signed fixed point.
// Fixed latency of FRAC_BITS+4 cycles from i2q2_valid to disc_valid.
import dll_discriminator_pkg::*;

module dll_discriminator #(
  parameter int IN_WIDTH  = DISC_IN_WIDTH,
  parameter int FRAC_BITS = DISC_FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  global_reset_n,
  input  logic                  clear,
  input  logic                  i2q2_valid,
  input  logic [IN_WIDTH-1:0]   i2q2_early,
  input  logic [IN_WIDTH-1:0]   i2q2_late,
  output logic                  busy,
  output logic                  disc_valid,
  output logic [FRAC_BITS+1:0]  disc,
  output logic                  disc_zero_den,
  output logic                  overrun
);

  state_t state_q, state_d;

  logic [IN_WIDTH-1:0] e_q, l_q;
  logic [IN_WIDTH-1:0] mag;
  logic [IN_WIDTH:0]   sum;
  logic                neg_q, zero_q;
  logic                start;
  logic                div_done;
  logic [FRAC_BITS:0]  quot;
  logic [FRAC_BITS:0]  q_eff;
  logic [FRAC_BITS+1:0] q_ext;

  assign sum   = {1'b0, e_q} + {1'b0, l_q};
  assign mag   = (e_q >= l_q) ? e_q - l_q : l_q - e_q;
  assign start = (state_q == ST_PREP) && !clear;
  assign busy  = state_q != ST_IDLE;
  assign q_eff = zero_q ? '0 : quot;
  assign q_ext = {1'b0, q_eff};

  serial_divider #(
    .DW(IN_WIDTH + 1),
    .QW(FRAC_BITS + 1)
  ) u_div (
    .clk   (clk),
    .rst_n (global_reset_n),
    .abort (clear),
    .start (start),
    .numer ({1'b0, mag}),
    .denom (sum),
    .done  (div_done),
    .quot  (quot)
  );

  always_ff @(posedge clk) begin
    if (!global_reset_n) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i2q2_valid) state_d = ST_PREP;
      ST_PREP: state_d = ST_DIV;
      ST_DIV:  if (div_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!global_reset_n) begin
      e_q           <= '0;
      l_q           <= '0;
      neg_q         <= 1'b0;
      zero_q        <= 1'b0;
      disc          <= '0;
      disc_zero_den <= 1'b0;
      disc_valid    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      disc_valid <= 1'b0;
      overrun    <= i2q2_valid && (state_q != ST_IDLE);
      if (state_q == ST_IDLE && i2q2_valid && !clear) begin
        e_q <= i2q2_early;
        l_q <= i2q2_late;
      end
      if (state_q == ST_PREP) begin
        neg_q  <= l_q > e_q;
        zero_q <= sum == '0;
      end
      // A clear arriving in DONE discards the result entirely.
      if (state_q == ST_DONE && !clear) begin
        disc          <= neg_q ? -q_ext : q_ext;
        disc_zero_den <= zero_q;
        disc_valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dll_discriminator.sv
// Scoreboard bench for dll_discriminator: directed vectors plus
// a short random sweep checked against an integer-division model.
module tb_dll_discriminator;

  localparam int IW  = 38;
  localparam int F   = 12;
  localparam int LAT = F + 4;

  logic          clk = 1'b0;
  logic          global_reset_n;
  logic          clear;
  logic          i2q2_valid;
  logic [IW-1:0] i2q2_early;
  logic [IW-1:0] i2q2_late;
  logic          busy;
  logic          disc_valid;
  logic [F+1:0]  disc;
  logic          disc_zero_den;
  logic          overrun;

  typedef struct {
    longint d;
    bit     zd;
    int     issue;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  dll_discriminator dut (
    .clk            (clk),
    .global_reset_n (global_reset_n),
    .clear          (clear),
    .i2q2_valid     (i2q2_valid),
    .i2q2_early     (i2q2_early),
    .i2q2_late      (i2q2_late),
    .busy           (busy),
    .disc_valid     (disc_valid),
    .disc           (disc),
    .disc_zero_den  (disc_zero_den),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (global_reset_n && disc_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_disc_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("disc", longint'($signed(disc)), e.d);
        chk("zero_den", longint'(disc_zero_den), longint'(e.zd));
        chk("latency", longint'(cyc - e.issue), LAT);
      end
    end
  end

  function automatic longint model(input longint e, input longint l);
    longint s, m, q;
    s = e + l;
    m = (e >= l) ? e - l : l - e;
    if (s == 0) return 0;
    q = (m << F) / s;
    return (l > e) ? -q : q;
  endfunction

  task automatic pulse(input longint e, input longint l);
    i2q2_early = IW'(e);
    i2q2_late  = IW'(l);
    i2q2_valid = 1'b1;
    @(negedge clk);
    i2q2_valid = 1'b0;
  endtask

  task automatic send(input longint e, input longint l,
                      input longint d, input bit zd);
    exp_t x;
    x.d = d;
    x.zd = zd;
    x.issue = cyc + 1;
    exp_q.push_back(x);
    pulse(e, l);
    repeat (LAT) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    longint e, l;
    global_reset_n = 1'b0;
    clear      = 1'b0;
    i2q2_valid = 1'b0;
    i2q2_early = '0;
    i2q2_late  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_valid", longint'(disc_valid), 0);
    chk("rst_disc", longint'(disc), 0);
    chk("rst_zd", longint'(disc_zero_den), 0);
    chk("rst_overrun", longint'(overrun), 0);
    global_reset_n = 1'b1;
    @(negedge clk);

    send(300, 100, 2048, 0);
    send(100, 300, -2048, 0);
    send(500, 500, 0, 0);
    send(0, 1000, -4096, 0);
    send(64'h3F_FFFF_FFFF, 0, 4096, 0);
    send(0, 0, 0, 1);
    send(1, 2, -1365, 0);
    drain();

    // Second valid while busy is dropped and flagged.
    begin
      exp_t x;
      x.d = 4096;
      x.zd = 0;
      x.issue = cyc + 1;
      exp_q.push_back(x);
    end
    pulse(1000, 0);
    repeat (4) @(negedge clk);
    chk("busy_in_div", longint'(busy), 1);
    pulse(5, 900);
    chk("overrun_pulse", longint'(overrun), 1);
    @(negedge clk);
    chk("overrun_one_cycle", longint'(overrun), 0);
    drain();
    repeat (20) @(negedge clk);
    chk("overrun_queue_empty", longint'(exp_q.size()), 0);

    // Reset during DIV zeroes outputs and suppresses the result.
    pulse(300, 100);
    repeat (6) @(negedge clk);
    global_reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_disc", longint'(disc), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_valid", longint'(disc_valid), 0);
    global_reset_n = 1'b1;
    repeat (20) @(negedge clk);

    // Clear during DIV keeps the last published result.
    send(0, 1000, -4096, 0);
    drain();
    pulse(300, 100);
    repeat (6) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_busy", longint'(busy), 0);
    repeat (20) @(negedge clk);
    chk("clear_hold_disc", longint'($signed(disc)), -4096);

    // Clear together with a valid in IDLE: dropped, no overrun.
    clear = 1'b1;
    pulse(300, 100);
    clear = 1'b0;
    chk("clear_idle_overrun", longint'(overrun), 0);
    chk("clear_idle_busy", longint'(busy), 0);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      e = longint'({$urandom, $urandom}) & 64'h3F_FFFF_FFFF;
      l = longint'({$urandom, $urandom}) & 64'h3F_FFFF_FFFF;
      e = e >> $urandom_range(0, IW - 1);
      l = l >> $urandom_range(0, IW - 1);
      send(e, l, model(e, l), (e + l) == 0);
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
